prog_loader: RTL
================

# prog_loader

Streaming program loader that fills the CPU instruction memory from a byte source, such as a UART receiver or a host bridge. It drives the memory's write port (`wraddress`, `data`, `wren`). It holds the CPU in reset-hold while loading and reports completion and checksum status. It sits between the byte-stream front end and the instruction memory, and is the only writer of that memory.

## Interface
Parameters:
- `ADDR_W`, 16, instruction-memory address width.
- `BASE_ADDR`, 0, first address written by each load.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  pulse that begins a load; ignored unless in IDLE or DONE.
- `byte_in`  in  8  stream byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts `byte_in` this cycle.
- `wraddress`  out  ADDR_W  instruction-memory write address.
- `data`  out  16  instruction-memory write data.
- `wren`  out  1  instruction-memory write enable; one-cycle pulse per word.
- `cpu_hold`  out  1  keeps the CPU stalled or reset while loading.
- `done`  out  1  sticky; load finished.
- `err`  out  1  sticky; checksum mismatch. Valid only when `done`=1.

## Operation
- Stream format, all bytes big-endian:
  - `LEN_HI`, `LEN_LO`: word count N, 16 bits.
  - N words, each sent high byte then low byte.
  - One checksum byte.
- Checksum = XOR of every byte before it, including both length bytes.
- A byte is accepted on a cycle with `byte_valid` && `byte_ready`.
- State machine:
  - IDLE: on `start` → LEN_HI. Clear `done`/`err`, reset the XOR accumulator, set address to `BASE_ADDR`.
  - LEN_HI → LEN_LO on accept.
  - LEN_LO → W_HI on accept if N≠0, else → CHK.
  - W_HI → W_LO on accept; latch the high byte.
  - W_LO → WRITE on accept; latch the low byte.
  - WRITE: one cycle. `wren`=1, `data`={hi,lo}, `wraddress`=current address. Then address+1 and remaining−1. Go to W_HI if remaining≠0, else → CHK.
  - CHK → DONE on accept. `err` = (`byte_in` ≠ accumulator).
  - DONE: `done`=1, `cpu_hold`=0. `start` → LEN_HI (restarts as from IDLE).
- `byte_ready` is 1 only in LEN_HI, LEN_LO, W_HI, W_LO and CHK. It is 0 in IDLE, WRITE and DONE.
- `cpu_hold` is 1 in every state except IDLE and DONE.
- Address arithmetic is modulo 2^ADDR_W. The address wraps silently, with no error.
- N is unsigned. N=65535 is legal.
- The word counter is 16 bits and decrements only in WRITE.
- `start` while in LEN_HI..CHK is ignored. There is no abort input.
- Stalls: `byte_valid` low in any accepting state holds the state indefinitely. There is no timeout.

## Timing
- Reset values, asynchronous on `rst_n`=0:
  - state IDLE
  - `byte_ready`=0, `wren`=0, `cpu_hold`=0, `done`=0, `err`=0
  - `wraddress`=0, `data`=0
- Reset mid-load aborts immediately. No further `wren` is issued. Words already written stay in memory.
- `start` seen at edge k → `byte_ready`=1 and `cpu_hold`=1 from cycle k+1.
- Low byte accepted at edge k → `wren`=1 during cycle k+1, with `wraddress`/`data` stable.
- The next high byte can be accepted at edge k+2.
- Peak rate: one word per 3 cycles.
- `wren`, `wraddress` and `data` are registered. No combinational path runs from `byte_valid` to `wren`.
- `byte_ready` is a function of state only, not of `byte_valid`.
- CHK byte accepted at edge k → `done`=1, `err` valid and `cpu_hold`=0 from cycle k+1.
- Memory readback: the instruction memory returns data one cycle after its read address is registered. A written word is readable by the CPU once `done`=1.

## Test plan
- **Basic load:** `start`, then stream 00 02 12 34 AB CD + checksum (00^02^12^34^AB^CD). Expect:
  - `wren` at 0x0000 with 0x1234, then at 0x0001 with 0xABCD
  - `done`=1, `err`=0, `cpu_hold` falls after the checksum byte.
- **Bad checksum:** same stream with checksum ^ 0x01 → both writes occur; `done`=1, `err`=1.
- **Empty load:** stream 00 00 00 → no `wren` pulse; `done`=1, `err`=0.
- **Back-pressure and stalls:** deassert `byte_valid` for random gaps, including inside a word. Expect:
  - identical writes to the basic load
  - `byte_ready` low during every WRITE cycle
  - exactly one `wren` per word.
- **Wrap:** `BASE_ADDR`=0xFFFF, N=2 → writes land at 0xFFFF, then 0x0000.
- **Reset and restart:** assert `rst_n`=0 after the first word's high byte. Expect all outputs at reset values and no further `wren`. Then restart with `start`; the full basic load completes correctly. `start` pulsed mid-load is ignored.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction-memory write port and loader status for prog_loader.
// The loader attaches through the slave modport; the stream source and memory side use master.
interface prog_loader_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] wraddress;
    logic [15:0]       data;
    logic              wren;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, wraddress, data, wren, cpu_hold, done, err
    );

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, wraddress, data, wren, cpu_hold, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Loads [len_hi len_lo {hi lo}*N xor] into instruction memory; wren is registered, one cycle after the low byte (3 cycles/word).
// byte_ready depends on state only and drops during WRITE/IDLE/DONE; a stalled byte_valid simply holds the state.
module prog_loader #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic          clock,
    input  logic          rst_n,
    prog_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_W_HI, S_W_LO, S_WRITE, S_CHK, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic              rdy, hold;
    logic [7:0]        acc;
    logic [7:0]        hi_byte;
    logic [15:0]       remaining;
    logic [ADDR_W-1:0] addr;
    logic              wren_q;
    logic [ADDR_W-1:0] wraddress_q;
    logic [15:0]       data_q;
    logic              done_q, err_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        hold      = 1'b1;
        case (state)
            S_IDLE: begin
                hold = 1'b0;
                if (bus.start) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                rdy = 1'b1;
                if (bus.byte_valid) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                rdy = 1'b1;
                if (bus.byte_valid)
                    state_nxt = ({hi_byte, bus.byte_in} == 16'd0) ? S_CHK : S_W_HI;
            end
            S_W_HI: begin
                rdy = 1'b1;
                if (bus.byte_valid) state_nxt = S_W_LO;
            end
            S_W_LO: begin
                rdy = 1'b1;
                if (bus.byte_valid) state_nxt = S_WRITE;
            end
            // remaining is never zero here, so 1 means this is the last word
            S_WRITE: state_nxt = (remaining == 16'd1) ? S_CHK : S_W_HI;
            S_CHK: begin
                rdy = 1'b1;
                if (bus.byte_valid) state_nxt = S_DONE;
            end
            S_DONE: begin
                hold = 1'b0;
                if (bus.start) state_nxt = S_LEN_HI;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= 8'd0;
            hi_byte     <= 8'd0;
            remaining   <= 16'd0;
            addr        <= BASE_ADDR;
            wren_q      <= 1'b0;
            wraddress_q <= '0;
            data_q      <= 16'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wren_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                        acc    <= 8'd0;
                        addr   <= BASE_ADDR;
                    end
                end
                S_LEN_HI, S_W_HI: begin
                    if (bus.byte_valid) begin
                        hi_byte <= bus.byte_in;
                        acc     <= acc ^ bus.byte_in;
                    end
                end
                S_LEN_LO: begin
                    if (bus.byte_valid) begin
                        remaining <= {hi_byte, bus.byte_in};
                        acc       <= acc ^ bus.byte_in;
                    end
                end
                // write port is loaded here so wren/wraddress/data come straight from flops
                S_W_LO: begin
                    if (bus.byte_valid) begin
                        wren_q      <= 1'b1;
                        wraddress_q <= addr;
                        data_q      <= {hi_byte, bus.byte_in};
                        acc         <= acc ^ bus.byte_in;
                    end
                end
                S_WRITE: begin
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 16'd1;
                end
                S_CHK: begin
                    if (bus.byte_valid) begin
                        done_q <= 1'b1;
                        err_q  <= (bus.byte_in != acc);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = rdy;
    assign bus.cpu_hold   = hold;
    assign bus.wren       = wren_q;
    assign bus.wraddress  = wraddress_q;
    assign bus.data       = data_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule
